sc_spi_arb: RTL and testbench
=============================

Name: sc_spi_arb

Overview:
- Two-port transaction arbiter and frame sequencer in front of the SPI Protocol Controller.
- Grants the SPI engine to one of two requesters (REQ0: register-access port, REQ1: flash/DMA port) with round-robin priority.
- Runs each granted transaction as 1..16 back-to-back frames, holding chip select low across frames via CSEXTEND.
- Routes the engine's TX word pointer and RX data path to the granted requester only.

Parameters:
- GAP, 2, idle cycles after a transaction before the next grant (CSB deasserted time); legal range 1..15.
- BSYTO, 4, cycles allowed from SPISTART until SPIBUSY must rise; legal range 2..15.

Ports:
- SPICLK  in  1  clock; all logic on rising edge.
- SYSRSTB  in  1  reset; synchronous, active-low.
- REQn (n=0,1)  in  1  transaction request; held high with stable attributes until DONEn.
- REQn_NFRM  in  4  number of frames minus 1.
- REQn_DWIDTH  in  9  per-frame data width value for the engine.
- REQn_BORDER  in  1  byte order.
- REQn_TXDATA  in  32  TX word selected by TXDPT_O.
- GNTn  out  1  grant; high from the grant cycle through the DONEn cycle.
- DONEn  out  1  one-cycle transaction-complete pulse.
- ERRn  out  1  one-cycle pulse; coincides with DONEn when the transaction aborted.
- FRMIDX  out  4  index of the current frame within the transaction.
- TXDPT_O  out  4  engine TXDPT forwarded to both requesters.
- RXVALIDn  out  1  engine RXVALID gated by GNTn.
- RXDATA_O  out  32  engine RXDATA, shared.
- RXDPT_O  out  4  engine RXDPT, shared.
- SPISTART  out  1  frame start pulse to the engine.
- SPIBUSY  in  1  engine busy.
- CSEXTEND  out  1  hold chip select between frames.
- DWIDTH  out  9  muxed from the granted requester.
- BORDER  out  1  muxed from the granted requester.
- TXDATA  out  32  muxed from the granted requester.
- TXDPT  in  4  engine TX word pointer.
- RXDATA  in  32  engine RX data.
- RXVALID  in  1  engine RX valid.
- RXDPT  in  4  engine RX word pointer.

Behaviour:
- Reset (SYSRSTB low at a clock edge): all outputs 0, state IDLE, priority pointer = REQ0.
  - Mid-transaction reset drops SPISTART and CSEXTEND immediately; no DONE or ERR is issued.
- States:
  - IDLE: if any REQ is high, grant and go to START. Both requesting: grant the priority holder. After every grant the priority pointer moves to the other port. Grant is registered: GNTn, CSEXTEND=1, FRMIDX=0 and the latched NFRM all take effect the cycle after REQ is sampled.
  - START: SPISTART=1 for exactly one cycle, then go to WBSY.
  - WBSY: wait for SPIBUSY=1, then go to WDONE. If SPIBUSY is not seen within BSYTO cycles: pulse ERRn and DONEn together, drop CSEXTEND and GNT, go to GAPW.
  - WDONE: on the SPIBUSY falling edge (SPIBUSY=0 sampled in WDONE):
    - FRMIDX < NFRM: FRMIDX+1, go to START. CSEXTEND stays 1; the next SPISTART is asserted the cycle after the fall.
    - FRMIDX == NFRM: DONEn pulse; CSEXTEND, GNTn and FRMIDX all reach 0 the following cycle; go to GAPW.
  - GAPW: count GAP cycles, then go to IDLE.
- Attribute latching: NFRM is latched at grant. DWIDTH, BORDER and TXDATA are combinational muxes on the granted port; when no grant is active they output 0.
- Arithmetic: FRMIDX is 4-bit. NFRM=15 gives 16 frames; there is no wrap-around inside a transaction.
- Deassertion of REQ during a transaction is ignored; the transaction completes.
- REQ still high after DONE is treated as a new request, arbitrated after GAPW.
- RXVALIDn = RXVALID & GNTn. RXVALID arriving in the DONE cycle is still delivered, because GNT is still high in that cycle.

Test Plan:
- REQ0 alone, NFRM=0, DWIDTH=7 -> one SPISTART pulse; CSEXTEND high through the frame; DONE0 1 cycle after SPIBUSY falls; GNT0 low next cycle; no grant for GAP=2 cycles.
- REQ1, NFRM=2 -> 3 SPISTART pulses, FRMIDX 0,1,2; CSEXTEND continuously 1 between frames; 3 RXVALID1 pulses with RXDATA_O; RXVALID0 stays 0.
- REQ0 and REQ1 asserted in the same cycle after reset -> REQ0 granted first, then REQ1; both kept high -> grants alternate 0,1,0.
- SPIBUSY tied 0 with BSYTO=4 -> ERR0 and DONE0 pulse together 4 cycles after SPISTART; CSEXTEND=0; next request is served normally.
- SYSRSTB low during frame 1 of a 4-frame transaction -> SPISTART, CSEXTEND, GNT, FRMIDX all 0 next edge; no DONE; priority pointer back to REQ0.
- Granted REQ0 with TXDPT stepping 0..3 -> TXDATA equals REQ0_TXDATA each cycle; REQ1_TXDATA changes have no effect.

Source files
------------

// File: rtl/sc_spi_arb.sv
// rtl/sc_spi_arb.sv - two-port round-robin arbiter and frame sequencer for the SPI engine
module sc_spi_arb #(
  parameter int GAP   = 2,
  parameter int BSYTO = 4
) (
  input  logic        SPICLK,
  input  logic        SYSRSTB,
  input  logic        REQ0,
  input  logic [3:0]  REQ0_NFRM,
  input  logic [8:0]  REQ0_DWIDTH,
  input  logic        REQ0_BORDER,
  input  logic [31:0] REQ0_TXDATA,
  input  logic        REQ1,
  input  logic [3:0]  REQ1_NFRM,
  input  logic [8:0]  REQ1_DWIDTH,
  input  logic        REQ1_BORDER,
  input  logic [31:0] REQ1_TXDATA,
  output logic        GNT0,
  output logic        GNT1,
  output logic        DONE0,
  output logic        DONE1,
  output logic        ERR0,
  output logic        ERR1,
  output logic [3:0]  FRMIDX,
  output logic [3:0]  TXDPT_O,
  output logic        RXVALID0,
  output logic        RXVALID1,
  output logic [31:0] RXDATA_O,
  output logic [3:0]  RXDPT_O,
  output logic        SPISTART,
  input  logic        SPIBUSY,
  output logic        CSEXTEND,
  output logic [8:0]  DWIDTH,
  output logic        BORDER,
  output logic [31:0] TXDATA,
  input  logic [3:0]  TXDPT,
  input  logic [31:0] RXDATA,
  input  logic        RXVALID,
  input  logic [3:0]  RXDPT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WBSY,
    S_WDONE,
    S_GAPW
  } state_t;

  // Last cycle index of the gap wait and of the busy-rise window (window counts the SPISTART cycle)
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
  localparam logic [3:0] BSY_LAST = 4'(BSYTO - 1);

  state_t     state;
  logic       prio;   // 0: REQ0 wins a tie, 1: REQ1 wins a tie
  logic [3:0] nfrm;
  logic [3:0] cnt;
  logic       pick1;

  // Arbitration decision: REQ1 wins when it is alone or holds the priority
  always_comb begin
    pick1 = REQ1 & (~REQ0 | prio);
  end

  // Transaction sequencer with registered grant, strobe and frame outputs
  always_ff @(posedge SPICLK) begin
    if (!SYSRSTB) begin
      state    <= S_IDLE;
      prio     <= 1'b0;
      nfrm     <= 4'd0;
      cnt      <= 4'd0;
      GNT0     <= 1'b0;
      GNT1     <= 1'b0;
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
      ERR0     <= 1'b0;
      ERR1     <= 1'b0;
      FRMIDX   <= 4'd0;
      SPISTART <= 1'b0;
      CSEXTEND <= 1'b0;
    end else begin
      DONE0    <= 1'b0;
      DONE1    <= 1'b0;
      ERR0     <= 1'b0;
      ERR1     <= 1'b0;
      SPISTART <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ0 | REQ1) begin
            GNT0     <= ~pick1;
            GNT1     <= pick1;
            nfrm     <= pick1 ? REQ1_NFRM : REQ0_NFRM;
            prio     <= ~pick1;
            CSEXTEND <= 1'b1;
            FRMIDX   <= 4'd0;
            SPISTART <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          cnt   <= 4'd1;
          state <= S_WBSY;
        end
        S_WBSY: begin
          if (SPIBUSY) begin
            state <= S_WDONE;
          end else if (cnt >= BSY_LAST) begin
            // Engine never went busy: abort, report on the granted port
            DONE0 <= GNT0;
            DONE1 <= GNT1;
            ERR0  <= GNT0;
            ERR1  <= GNT1;
            cnt   <= 4'd0;
            state <= S_GAPW;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_WDONE: begin
          if (!SPIBUSY) begin
            if (FRMIDX < nfrm) begin
              FRMIDX   <= FRMIDX + 4'd1;
              SPISTART <= 1'b1;
              state    <= S_START;
            end else begin
              DONE0 <= GNT0;
              DONE1 <= GNT1;
              cnt   <= 4'd0;
              state <= S_GAPW;
            end
          end
        end
        S_GAPW: begin
          // First GAPW cycle is the DONE cycle; grant and CS hold drop after it
          GNT0     <= 1'b0;
          GNT1     <= 1'b0;
          CSEXTEND <= 1'b0;
          FRMIDX   <= 4'd0;
          if (cnt >= GAP_LAST) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Attribute mux on the granted port, zero when nothing is granted
  always_comb begin
    DWIDTH = 9'd0;
    BORDER = 1'b0;
    TXDATA = 32'd0;
    if (GNT0) begin
      DWIDTH = REQ0_DWIDTH;
      BORDER = REQ0_BORDER;
      TXDATA = REQ0_TXDATA;
    end else if (GNT1) begin
      DWIDTH = REQ1_DWIDTH;
      BORDER = REQ1_BORDER;
      TXDATA = REQ1_TXDATA;
    end
  end

  // Engine pointers and RX data are shared; only RX valid is steered by grant
  always_comb begin
    TXDPT_O  = TXDPT;
    RXDATA_O = RXDATA;
    RXDPT_O  = RXDPT;
    RXVALID0 = RXVALID & GNT0;
    RXVALID1 = RXVALID & GNT1;
  end

endmodule

// File: tb/tb_sc_spi_arb.sv
// tb/tb_sc_spi_arb.sv - directed self-checking bench for sc_spi_arb
module tb_sc_spi_arb;

  logic        SPICLK = 1'b0;
  logic        SYSRSTB = 1'b0;
  logic        REQ0 = 1'b0, REQ1 = 1'b0;
  logic [3:0]  REQ0_NFRM = 4'd0, REQ1_NFRM = 4'd0;
  logic [8:0]  REQ0_DWIDTH = 9'd0, REQ1_DWIDTH = 9'd0;
  logic        REQ0_BORDER = 1'b0, REQ1_BORDER = 1'b0;
  logic [31:0] REQ0_TXDATA = 32'd0, REQ1_TXDATA = 32'd0;
  logic        GNT0, GNT1, DONE0, DONE1, ERR0, ERR1;
  logic [3:0]  FRMIDX, TXDPT_O, RXDPT_O;
  logic        RXVALID0, RXVALID1, SPISTART, CSEXTEND, BORDER;
  logic [31:0] RXDATA_O, TXDATA;
  logic [8:0]  DWIDTH;
  logic        SPIBUSY = 1'b0;
  logic [3:0]  TXDPT = 4'd0;
  logic [31:0] RXDATA = 32'd0;
  logic        RXVALID = 1'b0;
  logic [3:0]  RXDPT = 4'd0;

  sc_spi_arb #(.GAP(2), .BSYTO(4)) dut (
    .SPICLK(SPICLK), .SYSRSTB(SYSRSTB),
    .REQ0(REQ0), .REQ0_NFRM(REQ0_NFRM), .REQ0_DWIDTH(REQ0_DWIDTH),
    .REQ0_BORDER(REQ0_BORDER), .REQ0_TXDATA(REQ0_TXDATA),
    .REQ1(REQ1), .REQ1_NFRM(REQ1_NFRM), .REQ1_DWIDTH(REQ1_DWIDTH),
    .REQ1_BORDER(REQ1_BORDER), .REQ1_TXDATA(REQ1_TXDATA),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .ERR0(ERR0), .ERR1(ERR1), .FRMIDX(FRMIDX), .TXDPT_O(TXDPT_O),
    .RXVALID0(RXVALID0), .RXVALID1(RXVALID1), .RXDATA_O(RXDATA_O),
    .RXDPT_O(RXDPT_O), .SPISTART(SPISTART), .SPIBUSY(SPIBUSY),
    .CSEXTEND(CSEXTEND), .DWIDTH(DWIDTH), .BORDER(BORDER), .TXDATA(TXDATA),
    .TXDPT(TXDPT), .RXDATA(RXDATA), .RXVALID(RXVALID), .RXDPT(RXDPT)
  );

  always #5 SPICLK = ~SPICLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Engine model: busy for blen cycles after a start, one RX valid as busy falls
  logic       eng_en = 1'b1;
  int         blen = 3;
  int         bcnt = 0;
  logic [3:0] eng_frm = 4'd0;
  always @(negedge SPICLK) begin
    RXVALID = 1'b0;
    if (!GNT0 && !GNT1 && !SPIBUSY) eng_frm = 4'd0;
    if (!SYSRSTB) begin
      SPIBUSY = 1'b0;
      bcnt = 0;
    end else if (SPIBUSY) begin
      bcnt--;
      if (bcnt == 0) begin
        SPIBUSY = 1'b0;
        RXVALID = 1'b1;
        RXDATA  = 32'hA000_0000 | {28'd0, eng_frm};
        RXDPT   = eng_frm;
        eng_frm = eng_frm + 4'd1;
      end
    end else if (SPISTART && eng_en) begin
      SPIBUSY = 1'b1;
      bcnt = blen;
    end
  end

  // Monitor: cycle count, pulse counters and logs sampled just after each edge
  int         cyc = 0;
  int         n_start = 0, n_rxv0 = 0, n_rxv1 = 0, n_done0 = 0, n_err0 = 0, n_err1 = 0, n_csegap = 0;
  logic [3:0] frm_log[$];
  int         gnt_log[$];
  logic       pg0 = 1'b0, pg1 = 1'b0;
  logic [31:0] last_rx1 = 32'd0;
  logic [3:0]  last_rxdpt = 4'd0;
  always begin
    @(posedge SPICLK);
    #1;
    cyc++;
    if (SPISTART) begin n_start++; frm_log.push_back(FRMIDX); end
    if (RXVALID0) n_rxv0++;
    if (RXVALID1) begin n_rxv1++; last_rx1 = RXDATA_O; last_rxdpt = RXDPT_O; end
    if (DONE0) n_done0++;
    if (ERR0) n_err0++;
    if (ERR1) n_err1++;
    if ((GNT0 || GNT1) && !CSEXTEND) n_csegap++;
    if (GNT0 && !pg0) gnt_log.push_back(0);
    if (GNT1 && !pg1) gnt_log.push_back(1);
    pg0 = GNT0;
    pg1 = GNT1;
  end

  task automatic tick();
    @(posedge SPICLK);
    #2;
  endtask

  function automatic logic sig(input int w);
    case (w)
      0: return DONE0;
      1: return DONE1;
      2: return SPISTART;
      3: return GNT0;
      4: return GNT0 && (FRMIDX == 4'd1);
      5: return GNT1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w, input int maxc, output int at);
    int found;
    found = 0;
    at = 0;
    for (int i = 0; i < maxc && found == 0; i++) begin
      tick();
      if (sig(w)) begin found = 1; at = cyc; end
    end
    check(tag, found, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int t_s, t_d, t, b0, b1, b2, b3, b4, bg;
    int found;

    repeat (3) tick();
    check("rst_gnt", {GNT1, GNT0}, 0);
    check("rst_cse_start", {CSEXTEND, SPISTART}, 0);
    check("rst_frmidx", FRMIDX, 0);
    check("rst_done_err", {DONE0, DONE1, ERR0, ERR1}, 0);
    check("rst_mux", {DWIDTH, BORDER}, 0);
    check("rst_txdata", TXDATA, 0);
    @(negedge SPICLK) SYSRSTB = 1'b1;

    // Single frame on REQ0, REQ0 kept high to measure the gap to the regrant
    b0 = n_start;
    @(negedge SPICLK);
    REQ0 = 1'b1; REQ0_NFRM = 4'd0; REQ0_DWIDTH = 9'd7; REQ0_BORDER = 1'b1; REQ0_TXDATA = 32'h1234_5678;
    tick();
    t_s = cyc;
    check("t1_gnt", {GNT1, GNT0}, 2'b01);
    check("t1_start_cse", {SPISTART, CSEXTEND}, 2'b11);
    check("t1_mux", {DWIDTH, BORDER}, {9'd7, 1'b1});
    check("t1_txdata", TXDATA, 32'h1234_5678);
    wait_for("t1_done_wait", 0, 20, t_d);
    check("t1_done_lat", t_d - t_s, 4);
    check("t1_gnt_in_done", {GNT0, CSEXTEND, ERR0}, 3'b110);
    tick();
    check("t1_after_done", {GNT0, CSEXTEND, FRMIDX}, 0);
    check("t1_idle_dwidth", DWIDTH, 0);
    tick();
    check("t1_gap", GNT0, 0);
    tick();
    check("t1_regrant", GNT0, 1);
    check("t1_nstart", n_start - b0, 2);
    @(negedge SPICLK) REQ0 = 1'b0;
    wait_for("t1_done2_wait", 0, 20, t);
    repeat (4) tick();
    check("t1_no_regrant", GNT0, 0);

    // Three frames on REQ1
    blen = 2;
    b0 = n_start; b1 = frm_log.size(); b2 = n_rxv0; b3 = n_rxv1; b4 = n_csegap;
    @(negedge SPICLK);
    REQ1 = 1'b1; REQ1_NFRM = 4'd2; REQ1_DWIDTH = 9'd31; REQ1_BORDER = 1'b0;
    wait_for("t2_gnt_wait", 5, 5, t);
    check("t2_dwidth", DWIDTH, 31);
    @(negedge SPICLK) REQ1 = 1'b0;
    wait_for("t2_done_wait", 1, 60, t);
    check("t2_nstart", n_start - b0, 3);
    for (int i = 0; i < 3; i++) check("t2_frmidx", frm_log[b1 + i], i);
    check("t2_rxv1", n_rxv1 - b3, 3);
    check("t2_rxv0", n_rxv0 - b2, 0);
    check("t2_cse_hold", n_csegap - b4, 0);
    check("t2_rxdata", last_rx1, 32'hA000_0002);
    check("t2_rxdpt", last_rxdpt, 2);
    check("t2_err1", n_err1, 0);

    // Simultaneous requests after reset alternate 0,1,0
    @(negedge SPICLK) SYSRSTB = 1'b0;
    tick(); tick();
    bg = gnt_log.size();
    @(negedge SPICLK);
    SYSRSTB = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; REQ0_NFRM = 4'd0; REQ1_NFRM = 4'd0;
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      tick();
      if (gnt_log.size() >= bg + 3) found = 1;
    end
    check("t3_grants_wait", found, 1);
    check("t3_g0", gnt_log[bg], 0);
    check("t3_g1", gnt_log[bg + 1], 1);
    check("t3_g2", gnt_log[bg + 2], 0);
    @(negedge SPICLK); REQ0 = 1'b0; REQ1 = 1'b0;
    wait_for("t3_done_wait", 0, 20, t);

    // Busy timeout: engine silent
    b0 = n_err0;
    @(negedge SPICLK); eng_en = 1'b0; REQ0 = 1'b1;
    wait_for("t4_start_wait", 2, 10, t_s);
    wait_for("t4_done_wait", 0, 20, t_d);
    check("t4_lat", t_d - t_s, 4);
    check("t4_err", ERR0, 1);
    @(negedge SPICLK) REQ0 = 1'b0;
    tick();
    check("t4_drop", {CSEXTEND, GNT0}, 0);
    @(negedge SPICLK); eng_en = 1'b1; REQ0 = 1'b1;
    wait_for("t4_next_wait", 0, 40, t);
    check("t4_next_err", ERR0, 0);
    check("t4_nerr", n_err0 - b0, 1);
    @(negedge SPICLK) REQ0 = 1'b0;

    // Reset during frame 1 of a 4-frame transaction
    blen = 3;
    repeat (4) tick();
    @(negedge SPICLK); REQ0 = 1'b1; REQ0_NFRM = 4'd3;
    wait_for("t5_frm1_wait", 4, 40, t);
    b0 = n_done0;
    @(negedge SPICLK) SYSRSTB = 1'b0;
    tick();
    check("t5_rst_out", {SPISTART, CSEXTEND, GNT0, GNT1}, 0);
    check("t5_rst_frm", FRMIDX, 0);
    check("t5_rst_done", {DONE0, ERR0}, 0);
    @(negedge SPICLK);
    SYSRSTB = 1'b1; REQ0_NFRM = 4'd0; REQ1 = 1'b1; REQ1_NFRM = 4'd0;
    tick();
    check("t5_prio", {GNT1, GNT0}, 2'b01);
    check("t5_no_done", n_done0 - b0, 0);
    @(negedge SPICLK); REQ0 = 1'b0; REQ1 = 1'b0;
    wait_for("t5_done_wait", 0, 30, t);

    // TX data mux follows REQ0 while TXDPT steps
    blen = 12;
    repeat (4) tick();
    @(negedge SPICLK); REQ0 = 1'b1; REQ0_NFRM = 4'd0; REQ0_DWIDTH = 9'h100;
    wait_for("t6_gnt_wait", 3, 5, t);
    for (int i = 0; i < 4; i++) begin
      @(negedge SPICLK);
      TXDPT = 4'(i);
      REQ0_TXDATA = 32'h5A00_0000 + i;
      REQ1_TXDATA = 32'hDEAD_0000 + i;
      tick();
      check("t6_txdata", TXDATA, 32'h5A00_0000 + i);
      check("t6_txdpt", TXDPT_O, i);
    end
    check("t6_dwidth", DWIDTH, 9'h100);
    @(negedge SPICLK) REQ0 = 1'b0;
    wait_for("t6_done_wait", 0, 30, t);
    tick();
    check("t6_idle_txdata", TXDATA, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
